// File: rtl/qed_dup_scheduler.sv
// Generic buffer plus SQED issue controller: forwards originals, then replays them remapped to x16..x31.
// Latency: 1 cycle, every output is registered from the inputs sampled at the previous edge.
// Backpressure: stall freezes outputs, buffer and FSM; the instruction offered during a stall is dropped.

module qed_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Overflow/underflow are refused here so the count stays within 0..DEPTH.
    assign push_ok  = push && (count != CNT_W'(DEPTH));
    assign pop_ok   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem[wr_ptr] <= push_dat;
    end
endmodule

module qed_dup_scheduler #(
    parameter int DEPTH      = 8,
    parameter int PIPE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instruction,
    input  logic                   qed_exec_dup,
    input  logic                   stall,
    output logic [31:0]            qed_ifu_instruction,
    output logic                   qed_vld_out,
    output logic                   dup_mode,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fifo_full,
    output logic                   qed_ready
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DRN_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(PIPE_DEPTH - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {ST_ORIG, ST_DUP, ST_DRAIN, ST_DONE} state_t;

    state_t           state, state_nxt;
    logic [DRN_W-1:0] drain_cnt, drain_nxt;
    logic [31:0]      out_nxt;
    logic             vld_nxt, dup_nxt, ready_nxt;
    logic             push, pop;
    logic [31:0]      head_dat;

    // {rd, rs1, rs2} usage per opcode; all-zero marks an opcode outside the checked set.
    function automatic logic [2:0] field_use(input logic [6:0] op);
        case (op)
            7'b0110011:             return 3'b111;
            7'b0010011, 7'b0000011: return 3'b110;
            7'b0100011, 7'b1100011: return 3'b011;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [31:0] ins);
        logic [2:0] u;
        u = field_use(ins[6:0]);
        return (u != 3'b000) && !(u[2] && ins[11]) && !(u[1] && ins[19]) && !(u[0] && ins[24]);
    endfunction

    function automatic logic [31:0] remap(input logic [31:0] ins);
        logic [2:0]  u;
        logic [31:0] r;
        u = field_use(ins[6:0]);
        r = ins;
        if (u[2] && ins[11:7]  != 5'd0) r[11] = 1'b1;
        if (u[1] && ins[19:15] != 5'd0) r[19] = 1'b1;
        if (u[0] && ins[24:20] != 5'd0) r[24] = 1'b1;
        return r;
    endfunction

    qed_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (push && !stall),
        .push_dat (instruction),
        .pop      (pop && !stall),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign fifo_full = (fifo_count == CNT_W'(DEPTH));

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        out_nxt   = NOP;
        vld_nxt   = 1'b0;
        dup_nxt   = 1'b0;
        ready_nxt = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_ORIG, ST_DUP: begin
                if (state == ST_DUP || qed_exec_dup) begin
                    if (fifo_count != '0) begin
                        pop       = 1'b1;
                        out_nxt   = remap(head_dat);
                        vld_nxt   = 1'b1;
                        dup_nxt   = 1'b1;
                        // A single buffered entry empties on this pop, so skip straight to drain.
                        state_nxt = (fifo_count == CNT_W'(1)) ? ST_DRAIN : ST_DUP;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end else if (is_legal(instruction) && !fifo_full) begin
                    push    = 1'b1;
                    out_nxt = instruction;
                    vld_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_nxt = drain_cnt + DRN_W'(1);
                if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: ready_nxt = 1'b1;
            default: state_nxt = ST_ORIG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_ORIG;
            drain_cnt           <= '0;
            qed_ifu_instruction <= NOP;
            qed_vld_out         <= 1'b0;
            dup_mode            <= 1'b0;
            qed_ready           <= 1'b0;
        end else if (!stall) begin
            state               <= state_nxt;
            drain_cnt           <= drain_nxt;
            qed_ifu_instruction <= out_nxt;
            qed_vld_out         <= vld_nxt;
            dup_mode            <= dup_nxt;
            qed_ready           <= ready_nxt;
        end
    end
endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Bench for qed_dup_scheduler: fixed vector table, directed corner sequences, random run against a queue model.
module tb_qed_dup_scheduler;
    localparam int DEPTH      = 8;
    localparam int PIPE_DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        qed_exec_dup;
    logic        stall;
    logic [31:0] qed_ifu_instruction;
    logic        qed_vld_out;
    logic        dup_mode;
    logic [3:0]  fifo_count;
    logic        fifo_full;
    logic        qed_ready;

    int checks   = 0;
    int failures = 0;

    qed_dup_scheduler #(.DEPTH(DEPTH), .PIPE_DEPTH(PIPE_DEPTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .instruction         (instruction),
        .qed_exec_dup        (qed_exec_dup),
        .stall               (stall),
        .qed_ifu_instruction (qed_ifu_instruction),
        .qed_vld_out         (qed_vld_out),
        .dup_mode            (dup_mode),
        .fifo_count          (fifo_count),
        .fifo_full           (fifo_full),
        .qed_ready           (qed_ready)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of originals plus a phase (0 orig, 1 dup, 2 drain, 3 done).
    logic [31:0] q[$];
    int          m_phase, m_drain;
    logic [31:0] m_out;
    logic        m_vld, m_dup, m_ready;

    function automatic void uses(input logic [31:0] x, output bit ok, output bit urd, output bit urs1, output bit urs2);
        ok = 1; urd = 0; urs1 = 0; urs2 = 0;
        case (x[6:0])
            7'h33:        begin urd = 1; urs1 = 1; urs2 = 1; end
            7'h13, 7'h03: begin urd = 1; urs1 = 1; end
            7'h23, 7'h63: begin urs1 = 1; urs2 = 1; end
            default:      ok = 0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [31:0] x);
        bit ok, a, b, c;
        uses(x, ok, a, b, c);
        if (!ok) return 0;
        if (a && int'(x[11:7]) >= 16)  return 0;
        if (b && int'(x[19:15]) >= 16) return 0;
        if (c && int'(x[24:20]) >= 16) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] ref_remap(input logic [31:0] x);
        bit ok, a, b, c;
        logic [31:0] y;
        uses(x, ok, a, b, c);
        y = x;
        if (a && x[11:7]  != 0) y[11:7]  = x[11:7]  + 5'd16;
        if (b && x[19:15] != 0) y[19:15] = x[19:15] + 5'd16;
        if (c && x[24:20] != 0) y[24:20] = x[24:20] + 5'd16;
        return y;
    endfunction

    task automatic model_step(input logic r, input logic [31:0] ins, input logic ex, input logic st);
        if (r) begin
            q.delete();
            m_phase = 0; m_drain = 0;
            m_out = NOP; m_vld = 0; m_dup = 0; m_ready = 0;
        end else if (!st) begin
            m_out = NOP; m_vld = 0; m_dup = 0; m_ready = 0;
            if (m_phase == 1 || (m_phase == 0 && ex)) begin
                if (q.size() > 0) begin
                    m_out = ref_remap(q.pop_front());
                    m_vld = 1; m_dup = 1;
                    m_phase = (q.size() == 0) ? 2 : 1;
                end else begin
                    m_phase = 2;
                end
            end else if (m_phase == 0) begin
                if (ref_legal(ins) && q.size() < DEPTH) begin
                    q.push_back(ins);
                    m_out = ins; m_vld = 1;
                end
            end else if (m_phase == 2) begin
                m_drain++;
                if (m_drain == PIPE_DEPTH) m_phase = 3;
            end else begin
                m_ready = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out"},   qed_ifu_instruction, m_out);
        chk({tag, ".vld"},   qed_vld_out, m_vld);
        chk({tag, ".dup"},   dup_mode, m_dup);
        chk({tag, ".count"}, fifo_count, q.size());
        chk({tag, ".full"},  fifo_full, q.size() == DEPTH);
        chk({tag, ".ready"}, qed_ready, m_ready);
    endtask

    task automatic cycle(input logic r, input logic [31:0] ins, input logic ex, input logic st);
        reset = r; instruction = ins; qed_exec_dup = ex; stall = st;
        @(posedge clk);
        model_step(r, ins, ex, st);
        #1;
    endtask

    function automatic logic [31:0] add_ins(input int i);
        return {7'd0, 5'(i + 2), 5'(i + 1), 3'b000, 5'(i), 7'b0110011};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0: x[6:0] = 7'h33;
            1: x[6:0] = 7'h13;
            2: x[6:0] = 7'h03;
            3: x[6:0] = 7'h23;
            4: x[6:0] = 7'h63;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) begin x[11] = 0; x[19] = 0; x[24] = 0; end
        return x;
    endfunction

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        ex;
        logic [31:0] e_out;
        logic        e_vld;
        logic        e_dup;
        int          e_cnt;
        logic        e_rdy;
    } vec_t;

    function automatic vec_t mk(logic r, logic [31:0] i, logic e, logic [31:0] o, logic v, logic d, int c, logic y);
        vec_t t;
        t.rst = r; t.ins = i; t.ex = e; t.e_out = o; t.e_vld = v; t.e_dup = d; t.e_cnt = c; t.e_rdy = y;
        return t;
    endfunction

    vec_t tbl[13];
    int   n_dup;

    initial begin
        reset = 1; instruction = 0; qed_exec_dup = 0; stall = 0;
        tbl[0]  = mk(1, 32'h0,        0, NOP,          0, 0, 0, 0);
        tbl[1]  = mk(0, 32'h002081B3, 0, 32'h002081B3, 1, 0, 1, 0);
        tbl[2]  = mk(0, 32'h00700293, 0, 32'h00700293, 1, 0, 2, 0);
        tbl[3]  = mk(0, 32'h002881B3, 0, NOP,          0, 0, 2, 0);
        tbl[4]  = mk(0, 32'h0000006F, 0, NOP,          0, 0, 2, 0);
        tbl[5]  = mk(0, 32'h002081B3, 1, 32'h012889B3, 1, 1, 1, 0);
        tbl[6]  = mk(0, 32'h0,        1, 32'h00700A93, 1, 1, 0, 0);
        tbl[7]  = mk(0, 32'h0,        0, NOP,          0, 0, 0, 0);
        tbl[8]  = mk(0, 32'h0,        0, NOP,          0, 0, 0, 0);
        tbl[9]  = mk(0, 32'h0,        0, NOP,          0, 0, 0, 0);
        tbl[10] = mk(0, 32'h0,        0, NOP,          0, 0, 0, 0);
        tbl[11] = mk(0, 32'h0,        0, NOP,          0, 0, 0, 1);
        tbl[12] = mk(0, 32'h00700293, 0, NOP,          0, 0, 0, 1);

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rst, tbl[i].ins, tbl[i].ex, 1'b0);
            chk($sformatf("vec%0d.out", i),   qed_ifu_instruction, tbl[i].e_out);
            chk($sformatf("vec%0d.vld", i),   qed_vld_out, tbl[i].e_vld);
            chk($sformatf("vec%0d.dup", i),   dup_mode, tbl[i].e_dup);
            chk($sformatf("vec%0d.count", i), fifo_count, tbl[i].e_cnt);
            chk($sformatf("vec%0d.full", i),  fifo_full, tbl[i].e_cnt == DEPTH);
            chk($sformatf("vec%0d.ready", i), qed_ready, tbl[i].e_rdy);
        end

        // Fill to capacity, reject a ninth, replay all eight in order.
        cycle(1, 0, 0, 0); check_model("fill_rst");
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, add_ins(i), 0, 0); check_model($sformatf("fill%0d", i));
        end
        chk("fill.full_flag", fifo_full, 1);
        cycle(0, 32'h00700293, 0, 0); check_model("fill.ninth");
        n_dup = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle(0, rand_ins(), 1, 0); check_model($sformatf("replay%0d", i));
            if (qed_vld_out && i < DEPTH) begin
                chk($sformatf("replay%0d.order", i), qed_ifu_instruction, ref_remap(add_ins(i)));
                n_dup++;
            end
        end
        chk("replay.total", n_dup, DEPTH);

        // Stall in ORIG drops the offer; stall in DUP freezes the replay position.
        cycle(1, 0, 0, 0); check_model("stall_rst");
        for (int i = 0; i < 5; i++) begin
            cycle(0, add_ins(i), 0, 0); check_model($sformatf("stall_push%0d", i));
        end
        cycle(0, add_ins(9), 0, 1); check_model("stall_orig");
        cycle(0, 0, 1, 0); check_model("stall_dup0");
        for (int i = 0; i < 3; i++) begin
            cycle(0, rand_ins(), 1'($urandom_range(0, 1)), 1); check_model($sformatf("stall_hold%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            cycle(0, rand_ins(), 0, 0); check_model($sformatf("stall_resume%0d", i));
        end

        // Reset mid-replay with three entries left, then an immediate empty dup request.
        cycle(1, 0, 0, 0); check_model("rdup_rst");
        for (int i = 0; i < 5; i++) begin
            cycle(0, add_ins(i), 0, 0); check_model($sformatf("rdup_push%0d", i));
        end
        cycle(0, 0, 1, 0); check_model("rdup_pop0");
        cycle(0, 0, 1, 0); check_model("rdup_pop1");
        chk("rdup.count3", fifo_count, 3);
        cycle(1, 0, 0, 0); check_model("rdup_reset");
        cycle(0, add_ins(1), 1, 0); check_model("rdup_empty_dup");
        for (int i = 0; i < PIPE_DEPTH + 1; i++) begin
            cycle(0, 0, 0, 0); check_model($sformatf("rdup_drain%0d", i));
        end
        chk("rdup.ready", qed_ready, 1);

        // Random episodes against the model.
        for (int ep = 0; ep < 20; ep++) begin
            cycle(1, 0, 0, 0); check_model($sformatf("rnd%0d_rst", ep));
            for (int i = 0; i < 60; i++) begin
                cycle(1'($urandom_range(0, 49) == 0), rand_ins(),
                      1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 4) == 0));
                check_model($sformatf("rnd%0d_%0d", ep, i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
